// File: rtl/fetch_pkg.sv
// Fetch-stage shared types and sizing helpers.
// Imported by the fetch queue and fetch_unit.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus.
// Requests use valid/ready; responses are in-order, always accepted.
interface fetch_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [DATA_WIDTH-1:0] imem_req_addr;
  logic                  imem_resp_valid;
  logic [DATA_WIDTH-1:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );

endinterface

// File: rtl/fetch_fifo.sv
// First-word-fall-through FIFO with push, pop and flush.
// Depth need not be a power of two.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type T  = fetch_entry_t,
  parameter int  D  = 4,
  parameter int  CW = cnt_w(D)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  T              data_i,
  output T              data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int            PW   = ptr_w(D);
  localparam logic [PW-1:0] LAST = PW'(D - 1);

  T              mem_q [D];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(D));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_pop)
        rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
      if (do_push)
        wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; readers gate it with empty_o.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i)
      mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled RV32I fetch stage: PC generation, imem issue,
// fetch queue feeding decode, redirect with response discard.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH      = XLEN,
  parameter int                    DEPTH           = 4,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCsrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  fetch_if.master               imem,
  input  logic                  StallD,
  output logic                  ValidD,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCd,
  output logic [DATA_WIDTH-1:0] PCPlus4D
);

  localparam int QCW = cnt_w(DEPTH);
  localparam int OCW = cnt_w(MAX_OUTSTANDING);
  localparam int SW  = cnt_w(DEPTH + MAX_OUTSTANDING);

  localparam logic [DATA_WIDTH-1:0] STEP =
    DATA_WIDTH'(INSTR_BYTES);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [OCW-1:0]        drop_q, drop_d;
  logic [QCW-1:0]        occ;
  logic [OCW-1:0]        inflight;
  logic [SW-1:0]         credit;
  logic [DATA_WIDTH-1:0] tag_pc;
  fetch_entry_t          head;
  fetch_entry_t          entry;
  logic                  q_full, q_empty;
  logic                  tag_full, tag_empty;
  logic                  issue, accept, resp;
  logic                  keep, push, pop;

  // Entries already queued plus those in flight must fit.
  assign credit = SW'(occ) + SW'(inflight);

  assign issue  = rst && !PCsrcE && !tag_full &&
                  !q_full && (credit < SW'(DEPTH));
  assign accept = issue && imem.imem_req_ready;
  assign resp   = imem.imem_resp_valid;
  assign keep   = resp && (drop_q == '0);
  assign push   = keep && !PCsrcE;
  assign pop    = !q_empty && !StallD && !PCsrcE;

  assign entry = '{pc: tag_pc, instr: imem.imem_resp_data};

  assign imem.imem_req_valid = issue;
  assign imem.imem_req_addr  = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (PCsrcE)
      pc_d = PCTargetE;
    else if (accept)
      pc_d = pc_q + STEP;
  end

  // On redirect every response still owed becomes stale.
  always_comb begin
    drop_d = drop_q;
    if (PCsrcE)
      drop_d = inflight + OCW'(accept) - OCW'(resp);
    else if (resp && drop_q != '0)
      drop_d = drop_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  fetch_fifo #(
    .T (logic [DATA_WIDTH-1:0]),
    .D (MAX_OUTSTANDING)
  ) u_tag (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .pop_i   (resp),
    .flush_i (1'b0),
    .data_i  (pc_q),
    .data_o  (tag_pc),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (inflight)
  );

  fetch_fifo #(
    .T (fetch_entry_t),
    .D (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (PCsrcE),
    .data_i  (entry),
    .data_o  (head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (occ)
  );

  assign ValidD   = !q_empty;
  assign InstrD   = ValidD ? head.instr : '0;
  assign PCd      = ValidD ? head.pc : '0;
  assign PCPlus4D = ValidD ? head.pc + STEP : '0;

`ifndef SYNTHESIS
  resp_needs_req: assert property (
    @(posedge clk) disable iff (!rst)
    imem.imem_resp_valid |-> !tag_empty
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a queue-level model.
// Includes an imem responder with variable latency.
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PCsrcE = 1'b0;
  logic        StallD = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        ValidD;
  logic [31:0] InstrD, PCd, PCPlus4D;

  always #5 clk = ~clk;

  fetch_if #(.DATA_WIDTH(32)) bus ();

  fetch_unit #(
    .DATA_WIDTH      (32),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (RPC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .PCsrcE    (PCsrcE),
    .PCTargetE (PCTargetE),
    .imem      (bus),
    .StallD    (StallD),
    .ValidD    (ValidD),
    .InstrD    (InstrD),
    .PCd       (PCd),
    .PCPlus4D  (PCPlus4D)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int first_valid = -1;
  logic [31:0] first_pcd = '0;

  logic [31:0] m_pc;
  logic [31:0] m_q [$];
  logic [31:0] fl_pc [$];
  bit          fl_stale [$];
  logic [31:0] mem_addr [$];
  int          mem_cyc [$];
  logic [31:0] got [$];

  function automatic logic [31:0] code(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h cyc %0d",
               tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input bit redir, input logic [31:0] tgt,
                      input bit stall, input bit rdy,
                      input bit rsp_en);
    bit          rv;
    bit          m_rv;
    bit          stale;
    logic [31:0] rpc;
    cyc++;
    rv = rsp_en && mem_addr.size() > 0;
    if (rv) rv = mem_cyc[0] < cyc;
    PCsrcE    = redir;
    PCTargetE = tgt;
    StallD    = stall;
    bus.imem_req_ready  = rdy;
    bus.imem_resp_valid = rv;
    if (rv) bus.imem_resp_data = code(mem_addr[0]);
    else    bus.imem_resp_data = $urandom();
    #1;
    m_rv = !redir && fl_pc.size() < MAXO &&
           (m_q.size() + fl_pc.size()) < DEPTH;
    chk("req_valid", 32'(bus.imem_req_valid), 32'(m_rv));
    if (m_rv) chk("req_addr", bus.imem_req_addr, m_pc);
    chk("ValidD", 32'(ValidD), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("PCd", PCd, m_q[0]);
      chk("InstrD", InstrD, code(m_q[0]));
      chk("PCPlus4D", PCPlus4D, m_q[0] + 32'd4);
    end
    if (ValidD && first_valid < 0) begin
      first_valid = cyc;
      first_pcd   = PCd;
    end
    if (ValidD && !stall && !redir) got.push_back(PCd);
    if (bus.imem_req_valid && rdy) begin
      mem_addr.push_back(bus.imem_req_addr);
      mem_cyc.push_back(cyc);
    end
    if (rv) begin
      void'(mem_addr.pop_front());
      void'(mem_cyc.pop_front());
    end
    stale = 1'b1;
    rpc   = '0;
    if (rv && fl_pc.size() > 0) begin
      rpc   = fl_pc.pop_front();
      stale = fl_stale.pop_front();
    end
    if (redir) begin
      m_q.delete();
      foreach (fl_stale[i]) fl_stale[i] = 1'b1;
      m_pc = tgt;
    end else begin
      if (m_q.size() != 0 && !stall) void'(m_q.pop_front());
      if (rv && !stale) m_q.push_back(rpc);
      if (m_rv && rdy) begin
        fl_pc.push_back(m_pc);
        fl_stale.push_back(1'b0);
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    PCsrcE = 1'b0;
    StallD = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    #1;
    chk("rst_ValidD", 32'(ValidD), 32'd0);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_PCd", PCd, 32'd0);
    chk("rst_InstrD", InstrD, 32'd0);
    chk("rst_PCPlus4D", PCPlus4D, 32'd0);
    m_q.delete();
    fl_pc.delete();
    fl_stale.delete();
    mem_addr.delete();
    mem_cyc.delete();
    m_pc = RPC;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    first_valid = -1;
  endtask

  task automatic chk_got(input string tag, input int i,
                         input logic [31:0] exp);
    if (got.size() > i) chk(tag, got[i], exp);
    else chk(tag, 32'hBAD0_0000, exp);
  endtask

  initial begin
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    @(negedge clk);
    do_reset();

    // Streaming, always ready, one-cycle latency
    got.delete();
    repeat (12) step(0, '0, 0, 1, 1);
    chk("s1_first_cyc", 32'(first_valid), 32'd3);
    chk_got("s1_pc0", 0, 32'h0);
    chk_got("s1_pc1", 1, 32'h4);
    chk_got("s1_pc2", 2, 32'h8);

    // Decode stalled from reset: queue fills, no loss
    do_reset();
    got.delete();
    repeat (10) step(0, '0, 1, 1, 1);
    #1 chk("s2_full_noreq", 32'(bus.imem_req_valid), 32'd0);
    chk("s2_full_valid", 32'(ValidD), 32'd1);
    @(negedge clk);
    repeat (4) step(0, '0, 0, 0, 1);
    chk("s2_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk_got("s2_pc", i, 32'(i * 4));

    // Redirect with two requests in flight
    repeat (6) step(0, '0, 0, 0, 1);
    repeat (2) step(0, '0, 0, 1, 0);
    step(1, 32'h100, 0, 0, 0);
    first_valid = -1;
    repeat (10) step(0, '0, 0, 1, 1);
    chk("s3_first_pc", first_pcd, 32'h100);

    // Redirect coinciding with a response
    repeat (6) step(0, '0, 0, 0, 1);
    repeat (2) step(0, '0, 0, 1, 0);
    step(1, 32'h200, 0, 1, 1);
    first_valid = -1;
    repeat (10) step(0, '0, 0, 1, 1);
    chk("s4_first_pc", first_pcd, 32'h200);

    // PC wrap at the top of the address space
    step(1, 32'hFFFF_FFF8, 0, 1, 1);
    got.delete();
    repeat (10) step(0, '0, 0, 1, 1);
    chk_got("s5_pc0", 0, 32'hFFFF_FFF8);
    chk_got("s5_pc1", 1, 32'hFFFF_FFFC);
    chk_got("s5_pc2", 2, 32'h0);

    // Reset while entries are queued and requests in flight
    repeat (2) step(0, '0, 1, 1, 1);
    repeat (2) step(0, '0, 1, 1, 0);
    do_reset();
    first_valid = -1;
    repeat (8) step(0, '0, 0, 1, 1);
    chk("s6_restart_pc", first_pcd, RPC);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      step($urandom_range(19) == 0,
           $urandom() & 32'hFFFF_FFFC,
           $urandom_range(2) == 0,
           $urandom_range(2) != 0,
           $urandom_range(2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
